// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25xx-style serial EEPROM (READ/WRITE/WREN/WRDI/RDSR).
// SPI pins are oversampled on clk; storage also has a back-door load port.
module spi_eeprom_responder #(
  parameter int DEPTH      = 128,
  parameter int ADDR_BYTES = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       eeprom_cs,
  input  logic       eeprom_clk,
  input  logic       eeprom_in,
  output logic       eeprom_out,
  output logic       miso_oe,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  output logic       busy,
  output logic       wel
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(8*ADDR_BYTES);
  localparam logic [CW-1:0] CNT_BYTE = CW'(7);
  localparam logic [CW-1:0] CNT_ADDR = CW'(8*ADDR_BYTES-1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
  logic            cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d, cs_seen_q, cs_seen_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      shin_q, shin_d;
  logic [7:0]      shout_q, shout_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            is_rd_q, is_rd_d, out_q, out_d, oe_q, oe_d, wel_q, wel_d, stored_q, stored_d;
  logic [7:0]      mem_q [DEPTH];

  logic            cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic            byte_done, addr_done, spi_we;
  logic [7:0]      rx_byte, tx_byte;
  logic [AW-1:0]   addr_inc;
  logic            unused_load_hi;

  assign cs_s      = cs_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // cs sync resets low so a cs held low through reset never looks like a fresh fall
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign rx_byte   = {shin_q, mosi_s};
  assign byte_done = sclk_rise && (cnt_q == CNT_BYTE);
  assign addr_done = sclk_rise && (cnt_q == CNT_ADDR);
  assign addr_inc  = addr_q + 1'b1;
  assign unused_load_hi = ^load_addr[7:AW];

  assign eeprom_out = out_q;
  assign miso_oe    = oe_q;
  assign wel        = wel_q;
  assign busy       = ~cs_s & cs_seen_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cs_sync_q   <= 2'b00;
      sclk_sync_q <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_seen_q   <= 1'b0;
      cnt_q       <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      addr_q      <= '0;
      is_rd_q     <= 1'b0;
      out_q       <= 1'b0;
      oe_q        <= 1'b0;
      wel_q       <= 1'b0;
      stored_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      cs_seen_q   <= cs_seen_d;
      cnt_q       <= cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      addr_q      <= addr_d;
      is_rd_q     <= is_rd_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      wel_q       <= wel_d;
      stored_q    <= stored_d;
    end
  end

  // Back-door load is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (spi_we)  mem_q[addr_q] <= rx_byte;
    if (load_en) mem_q[load_addr[AW-1:0]] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (byte_done) begin
          case (rx_byte)
            8'h03, 8'h02: state_d = ADDR;
            8'h05:        state_d = STATUS;
            default:      state_d = IGNORE;
          endcase
        end
        ADDR: if (addr_done) state_d = is_rd_q ? RD_DATA : WR_DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    cs_sync_d   = {cs_sync_q[0], eeprom_cs};
    sclk_sync_d = {sclk_sync_q[0], eeprom_clk};
    mosi_sync_d = {mosi_sync_q[0], eeprom_in};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
    cs_seen_d   = cs_seen_q | cs_s;
    cnt_d    = cnt_q;
    shin_d   = shin_q;
    shout_d  = shout_q;
    addr_d   = addr_q;
    is_rd_d  = is_rd_q;
    out_d    = out_q;
    oe_d     = oe_q;
    wel_d    = wel_q;
    stored_d = stored_q;
    spi_we   = 1'b0;
    tx_byte  = '0;
    if (cs_rise) begin
      cnt_d    = '0;
      oe_d     = 1'b0;
      out_d    = 1'b0;
      stored_d = 1'b0;
      if (state_q == WR_DATA && stored_q) wel_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) cnt_d = '0;
        CMD: if (sclk_rise) begin
          shin_d = rx_byte[6:0];
          cnt_d  = byte_done ? '0 : cnt_q + 1'b1;
          if (byte_done) begin
            is_rd_d = (rx_byte == 8'h03);
            if (rx_byte == 8'h06) wel_d = 1'b1;
            if (rx_byte == 8'h04) wel_d = 1'b0;
          end
        end
        ADDR: if (sclk_rise) begin
          addr_d = {addr_q[AW-2:0], mosi_s};
          cnt_d  = addr_done ? '0 : cnt_q + 1'b1;
        end
        WR_DATA: if (sclk_rise) begin
          shin_d = rx_byte[6:0];
          cnt_d  = byte_done ? '0 : cnt_q + 1'b1;
          if (byte_done && wel_q) begin
            spi_we   = 1'b1;
            addr_d   = addr_inc;
            stored_d = 1'b1;
          end
        end
        RD_DATA, STATUS: if (sclk_fall) begin
          // cnt_q==0 with oe set marks a byte boundary: next byte loads on this fall
          if (!oe_q || cnt_q == '0) begin
            if (state_q == STATUS) tx_byte = {6'b0, wel_q, 1'b0};
            else if (oe_q) begin
              tx_byte = mem_q[addr_inc];
              addr_d  = addr_inc;
            end else tx_byte = mem_q[addr_q];
            out_d   = tx_byte[7];
            shout_d = {tx_byte[6:0], 1'b0};
            oe_d    = 1'b1;
            cnt_d   = CW'(1);
          end else begin
            out_d   = shout_q[7];
            shout_d = {shout_q[6:0], 1'b0};
            cnt_d   = (cnt_q == CNT_BYTE) ? '0 : cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Scoreboard bench for spi_eeprom_responder: bit-banged SPI initiator plus a byte model of the array.
module tb_spi_eeprom_responder;
  localparam int DEPTH = 128;
  localparam int HP    = 6;

  logic       clk = 1'b0, nreset = 1'b0;
  logic       eeprom_cs = 1'b1, eeprom_clk = 1'b0, eeprom_in = 1'b0, load_en = 1'b0;
  logic [7:0] load_addr = '0, load_data = '0;
  logic       eeprom_out, miso_oe, busy, wel;

  int         n_chk = 0, n_pass = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] exp_q [$];
  logic       wel_m = 1'b0;

  always #5 clk = ~clk;

  spi_eeprom_responder #(.DEPTH(DEPTH), .ADDR_BYTES(3)) dut (
    .clk(clk), .nreset(nreset), .eeprom_cs(eeprom_cs), .eeprom_clk(eeprom_clk),
    .eeprom_in(eeprom_in), .eeprom_out(eeprom_out), .miso_oe(miso_oe),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .wel(wel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xbit(input logic b, output logic r);
    eeprom_in = b;
    wait_clk(HP);
    r = eeprom_out;
    eeprom_clk = 1'b1;
    wait_clk(HP);
    eeprom_clk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      logic r;
      xbit(tx[b], r);
      rx[b] = r;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    eeprom_cs = 1'b0;
    wait_clk(HP);
  endtask

  task automatic cs_high();
    wait_clk(HP);
    eeprom_cs = 1'b1;
    wait_clk(HP);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [7:0] a);
    logic [7:0] rx;
    xfer(op, rx); xfer(8'h00, rx); xfer(8'h00, rx); xfer(a, rx);
  endtask

  task automatic op1(input logic [7:0] op);
    logic [7:0] rx;
    cs_low();
    xfer(op, rx);
    cs_high();
    if (op == 8'h06) wel_m = 1'b1;
    if (op == 8'h04) wel_m = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int n, input string tag);
    logic [7:0] rx;
    cs_low();
    hdr(8'h03, a);
    for (int i = 0; i < n; i++) exp_q.push_back(model[(int'(a) + i) % DEPTH]);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, exp_q.pop_front());
    end
    chk({tag, "_oe"}, miso_oe, 1'b1);
    cs_high();
    chk({tag, "_oe_off"}, miso_oe, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    logic [7:0] rx;
    cs_low();
    hdr(8'h02, a);
    xfer(d0, rx);
    if (n > 1) xfer(d1, rx);
    cs_high();
    if (wel_m) begin
      model[a] = d0;
      if (n > 1) model[(int'(a) + 1) % DEPTH] = d1;
      wel_m = 1'b0;
    end
  endtask

  task automatic rdsr(input int n, input string tag);
    logic [7:0] rx;
    cs_low();
    xfer(8'h05, rx);
    for (int i = 0; i < n; i++) exp_q.push_back({6'b0, wel_m, 1'b0});
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, exp_q.pop_front());
    end
    cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    logic r;
    wait_clk(3);
    chk("rst_out", eeprom_out, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wel", wel, 1'b0);
    nreset = 1'b1;
    wait_clk(4);

    for (int i = 0; i < DEPTH; i++) begin
      model[i] = (i < 100) ? 8'(i) : 8'(i * 3 + 1);
      load_en = 1'b1; load_addr = 8'(i); load_data = model[i];
      @(negedge clk);
    end
    load_en = 1'b0;

    cs_low();
    chk("busy_cs_low", busy, 1'b1);
    cs_high();
    chk("busy_cs_high", busy, 1'b0);

    rd(8'h00, 100, "rd100");
    rd(8'(DEPTH - 2), 4, "rd_wrap");

    wr(8'h10, 8'hAA, 8'h00, 1);
    chk("nowren_wel", wel, 1'b0);
    rd(8'h10, 1, "nowren_rd");

    op1(8'h06);
    chk("wren_wel", wel, 1'b1);
    wr(8'h10, 8'hAA, 8'h00, 1);
    chk("wr_wel_clr", wel, 1'b0);
    rd(8'h10, 1, "wr_rd");

    op1(8'h06);
    wr(8'h7F, 8'h11, 8'h22, 2);
    rd(8'h7F, 2, "wr_wrap_rd");

    op1(8'h06);
    rdsr(3, "rdsr_wel1");
    op1(8'h04);
    chk("wrdi_wel", wel, 1'b0);
    rdsr(2, "rdsr_wel0");

    op1(8'h06);
    cs_low();
    hdr(8'h02, 8'h20);
    for (int b = 0; b < 5; b++) xbit(1'b1, r);
    eeprom_cs = 1'b1;
    wait_clk(HP);
    chk("part_oe", miso_oe, 1'b0);
    chk("part_busy", busy, 1'b0);
    chk("part_wel", wel, 1'b1);
    rd(8'h20, 1, "part_rd");

    cs_low();
    hdr(8'h03, 8'h00);
    xfer(8'h00, rx);
    chk("mid_oe", miso_oe, 1'b1);
    xbit(1'b0, r);
    nreset = 1'b0;
    wel_m = 1'b0;
    wait_clk(2);
    chk("nrst_out", eeprom_out, 1'b0);
    chk("nrst_oe", miso_oe, 1'b0);
    chk("nrst_wel", wel, 1'b0);
    nreset = 1'b1;
    wait_clk(HP);
    xfer(8'h05, rx);
    xfer(8'h00, rx);
    chk("nrst_no_start", miso_oe, 1'b0);
    cs_high();
    rd(8'h05, 1, "post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
